// File: rtl/msg_entry.sv
// Message entry front end: debounced buttons build a right-aligned hex message,
// which is offered to the hasher over valid/ready and then held for display.
module msg_entry #(
    parameter int MSG_BITS        = 120,
    parameter int DEBOUNCE_CYCLES = 1250000,
    localparam int NIBBLES        = MSG_BITS / 4,
    localparam int LEN_W          = $clog2(NIBBLES + 1)
) (
    input  logic                sysclk_125mhz,
    input  logic                rst,
    input  logic [3:0]          nibble_in,
    input  logic                btn_enter,
    input  logic                btn_delete,
    input  logic                btn_done,
    output logic [MSG_BITS-1:0] msg,
    output logic [LEN_W-1:0]    msg_len,
    output logic                msg_valid,
    input  logic                msg_ready,
    output logic                full,
    output logic                busy,
    output logic [15:0]         preview
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(NIBBLES);

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        SEND  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    logic [2:0] btn_raw;
    logic [2:0] pulse;

    assign btn_raw = {btn_done, btn_delete, btn_enter};

    // Per button: 2-flop synchronizer, stability counter, rising-edge pulse.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_deb
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge sysclk_125mhz or negedge rst) begin
                if (!rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= btn_raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    if (sync2_reg == stable_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        stable_reg <= ~stable_reg;
                        cnt_reg    <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
            end

            assign pulse[gi] = stable_reg & ~stable_d_reg;
        end
    endgenerate

    logic pulse_enter;
    logic pulse_delete;
    logic pulse_done;

    assign pulse_enter  = pulse[0];
    assign pulse_delete = pulse[1];
    assign pulse_done   = pulse[2];

    state_t              state_reg, state_next;
    logic [MSG_BITS-1:0] msg_reg, msg_next;
    logic [LEN_W-1:0]    len_reg, len_next;
    logic                valid_reg, valid_next;
    logic                full_reg, full_next;

    always_ff @(posedge sysclk_125mhz or negedge rst) begin
        if (!rst) begin
            state_reg <= ENTRY;
            msg_reg   <= '0;
            len_reg   <= '0;
            valid_reg <= 1'b0;
            full_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            msg_reg   <= msg_next;
            len_reg   <= len_next;
            valid_reg <= valid_next;
            full_reg  <= full_next;
        end
    end

    // Done outranks delete, which outranks enter; a consumed pulse masks the rest.
    always_comb begin
        state_next = state_reg;
        msg_next   = msg_reg;
        len_next   = len_reg;
        valid_next = valid_reg;
        case (state_reg)
            ENTRY: begin
                if (pulse_done) begin
                    if (len_reg != '0) begin
                        state_next = SEND;
                        valid_next = 1'b1;
                    end
                end else if (pulse_delete) begin
                    if (len_reg != '0) begin
                        msg_next = {4'h0, msg_reg[MSG_BITS-1:4]};
                        len_next = len_reg - 1'b1;
                    end
                end else if (pulse_enter) begin
                    if (len_reg != LEN_MAX) begin
                        msg_next = {msg_reg[MSG_BITS-5:0], nibble_in};
                        len_next = len_reg + 1'b1;
                    end
                end
            end
            SEND: begin
                if (valid_reg && msg_ready) begin
                    state_next = HOLD;
                    valid_next = 1'b0;
                end
            end
            HOLD: begin
                if (pulse_done) begin
                    msg_next   = '0;
                    len_next   = '0;
                    state_next = ENTRY;
                end
            end
            default: begin
                state_next = ENTRY;
                valid_next = 1'b0;
            end
        endcase
        full_next = (len_next == LEN_MAX);
    end

    assign msg       = msg_reg;
    assign msg_len   = len_reg;
    assign msg_valid = valid_reg;
    assign full      = full_reg;
    assign busy      = (state_reg != ENTRY);
    assign preview   = msg_reg[15:0];

endmodule

// File: doc/msg_entry.md
Name: msg_entry

Overview:
- Front end of the hash demo: builds the message that feeds the SHA-256 core from board switches and buttons.
- Replaces the hard-coded message constant.
- One hex nibble is captured per debounced button press.
- Delete and submit are supported.
- The finished message is handed to the hasher over a valid/ready handshake.
- A 16-bit preview of the last four entered nibbles is exported for the 7-segment path.

Parameters:
- MSG_BITS, 120, message register width in bits; must be a multiple of 4.
- DEBOUNCE_CYCLES, 1250000, consecutive stable cycles needed to accept a button level change (10 ms at 125 MHz).
- NIBBLES, MSG_BITS/4, derived capacity in nibbles.
- LEN_W, $clog2(NIBBLES+1), derived width of the length count.

Ports:
- sysclk_125mhz  input  1  system clock.
- rst  input  1  asynchronous, active-low reset.
- nibble_in  input  4  hex digit from sw[3:0]; sampled on an enter pulse.
- btn_enter  input  1  raw button: append nibble.
- btn_delete  input  1  raw button: remove last nibble.
- btn_done  input  1  raw button: submit message / start new message.
- msg  output  MSG_BITS  message, right-aligned; last entered nibble is in msg[3:0].
- msg_len  output  LEN_W  number of valid nibbles.
- msg_valid  output  1  message offered to hasher.
- msg_ready  input  1  hasher accepts message.
- full  output  1  msg_len == NIBBLES.
- busy  output  1  state is not ENTRY.
- preview  output  16  equal to msg[15:0].

Behaviour:
- Reset (rst low, async):
  - msg = 0, msg_len = 0, msg_valid = 0, full = 0, busy = 0.
  - State = ENTRY.
  - All debouncer stable levels = 0; all counters = 0.
- Input conditioning, per button:
  - 2-flop synchronizer, then a debounce counter.
  - The counter runs while the synced level differs from the stable level.
  - It clears whenever the levels match.
  - At DEBOUNCE_CYCLES-1 the stable level flips and the counter clears.
  - A rising edge of the stable level gives a 1-cycle pulse.
  - Latency from a clean raw edge to the pulse is 2 + DEBOUNCE_CYCLES cycles.
  - Release generates no pulse.
- nibble_in is sampled in the same cycle as the enter pulse; no synchronizer is needed because the switches are quasi-static.
- Pulse priority when pulses coincide in one cycle: done > delete > enter; lower-priority pulses in that cycle are dropped.
- ENTRY state:
  - Enter with msg_len < NIBBLES: msg <= {msg[MSG_BITS-5:0], nibble_in}; msg_len++.
  - Enter when full: ignored; msg and msg_len are unchanged.
  - Delete with msg_len > 0: msg <= {4'h0, msg[MSG_BITS-1:4]}; msg_len--.
  - Delete when msg_len == 0: ignored.
  - Done with msg_len > 0: go to SEND; msg_valid <= 1 on the next cycle.
  - Done when msg_len == 0: ignored.
- SEND state:
  - msg_valid stays 1; msg and msg_len are frozen.
  - Transfer occurs on a cycle where msg_valid && msg_ready; next state is HOLD and msg_valid <= 0.
  - msg_ready may be high before valid; the transfer then completes in the first SEND cycle.
  - Enter, delete and done pulses are ignored.
- HOLD state:
  - msg and msg_len are frozen, so the display can show the hash of the message.
  - Enter and delete are ignored.
  - Done: msg <= 0, msg_len <= 0, go to ENTRY.
- Status outputs:
  - busy = 1 in SEND and HOLD.
  - full is registered and consistent with msg_len in the same cycle.
- Reset asserted mid-SEND drops msg_valid immediately (async); the hasher must tolerate an offer withdrawn before acceptance.
- All state is updated only on the rising edge of sysclk_125mhz, except the async reset.

Test Plan:
- Sim uses DEBOUNCE_CYCLES = 4.
- Reset then enter A, B, C, D (clean presses) -> msg_len = 4, preview = 16'hABCD, msg[MSG_BITS-1:16] = 0, msg_valid = 0.
- Bounce: btn_enter toggles every 2 cycles for 20 cycles, then holds high -> exactly one pulse, msg_len increments by 1, pulse 6 cycles after the final stable edge.
- Enter 30 nibbles of 4'h5, then a 31st press of 4'hF -> full = 1, msg_len = 30, msg = all 5s; delete -> msg_len = 29, msg[3:0] = 5, msg[119:116] = 0, full = 0.
- Delete with msg_len = 0 -> no change. Done with msg_len = 0 -> stays ENTRY, msg_valid = 0.
- Enter 1, 2; done with msg_ready = 0 for 10 cycles, then 1 -> msg_valid high exactly until the accept cycle; msg = 8'h12 is stable throughout. Enter pressed during SEND -> ignored. Second done -> msg = 0, msg_len = 0, busy = 0.
- Simultaneous done and enter pulses (same-cycle debounced edges) in ENTRY with msg_len = 3 -> SEND entered, msg_len remains 3.
- rst low for 1 cycle during SEND -> msg_valid, msg and msg_len go to 0 asynchronously; state = ENTRY after release.
